// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the 3-stage pipeline sequencer.
// Revision: 1.0
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_REDIR = 2'd1;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  localparam logic [3:0] CAUSE_ECALL  = 4'd11;
  localparam logic [3:0] CAUSE_EBREAK = 4'd3;
  localparam logic [3:0] CAUSE_BUSERR = 4'd5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_TRAP     = 2'd3
  } state_t;

  // id folds the EBREAK/ECALL distinction into bit 20 of the trapping PC word
  function automatic logic [3:0] trap_cause_of(input logic ebreak_bit);
    return ebreak_bit ? CAUSE_EBREAK : CAUSE_ECALL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// pipe_ctrl_hazard_detect: combinational load-use comparator between EX and ID.
// Revision: 1.0
`default_nettype none

module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic [1:0] ex_mem_rw,
  input  logic [4:0] ex_rd_waddr,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_raddr,
  input  logic [4:0] id_rs2_raddr,
  output logic       load_use
);

  assign load_use = ex_valid && (ex_mem_rw == MEM_READ) && (ex_rd_waddr != 5'd0) &&
                    id_valid && ((ex_rd_waddr == id_rs1_raddr) || (ex_rd_waddr == id_rs2_raddr));

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: PC-write/stall/flush/redirect sequencer with memory wait, FENCE.I drain and trap entry.
// Revision: 1.0
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FENCEI_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_WIDTH     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_raddr,
  input  logic [4:0]  id_rs2_raddr,
  input  logic        id_fencei,
  input  logic        id_trap,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd_waddr,
  input  logic [1:0]  ex_mem_rw,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] trap_vec,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] redirect_addr,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        ex_stall,
  output logic        icache_inv,
  output logic        trap_o,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic [1:0]  state_o
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [3:0]             trap_cause_q, trap_cause_d;
  logic [31:0]            trap_epc_q, trap_epc_d;
  logic [31:0]            fencei_pc_q, fencei_pc_d;
  logic                   load_use;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .ex_valid     (ex_valid),
    .ex_mem_rw    (ex_mem_rw),
    .ex_rd_waddr  (ex_rd_waddr),
    .id_valid     (id_valid),
    .id_rs1_raddr (id_rs1_raddr),
    .id_rs2_raddr (id_rs2_raddr),
    .load_use     (load_use)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    trap_cause_d  = trap_cause_q;
    trap_epc_d    = trap_epc_q;
    fencei_pc_d   = fencei_pc_q;
    pc_we         = 1'b1;
    pc_sel        = PC_SEQ;
    redirect_addr = '0;
    ifid_we       = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    ex_stall      = 1'b0;
    icache_inv    = 1'b0;
    trap_o        = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (ex_valid && ex_br_taken) begin
          pc_sel        = PC_REDIR;
          redirect_addr = ex_br_target;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
        end else if (mem_req && !mem_ack) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          ex_stall = 1'b1;
          state_d  = ST_MEM_WAIT;
          cnt_d    = CNT_WIDTH'(1);
        end else if (load_use) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end else if (id_valid && id_trap) begin
          pc_sel        = PC_REDIR;
          redirect_addr = trap_vec;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          trap_epc_d    = id_pc;
          trap_cause_d  = trap_cause_of(id_pc[20]);
          state_d       = ST_TRAP;
        end else if (id_valid && id_fencei) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          icache_inv  = 1'b1;
          fencei_pc_d = id_pc;
          state_d     = ST_DRAIN;
          cnt_d       = CNT_WIDTH'(FENCEI_CYCLES - 1);
        end
      end

      ST_MEM_WAIT: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        ex_stall = 1'b1;
        if (mem_ack) begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          ex_stall = 1'b0;
          state_d  = ST_RUN;
        end else if (cnt_q == CNT_WIDTH'(MEM_TIMEOUT - 1)) begin
          // PC must load the redirect; fliop1 stays held and is flushed instead
          pc_we         = 1'b1;
          pc_sel        = PC_REDIR;
          redirect_addr = trap_vec;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          ex_stall      = 1'b0;
          trap_cause_d  = CAUSE_BUSERR;
          trap_epc_d    = id_pc;
          state_d       = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      ST_DRAIN: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
        if (cnt_q == '0) begin
          pc_we         = 1'b1;
          pc_sel        = PC_REDIR;
          redirect_addr = fencei_pc_q + 32'd4;
          ifid_flush    = 1'b1;
          state_d       = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end

      ST_TRAP: begin
        trap_o     = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase

    if (rst) begin
      pc_we         = 1'b0;
      pc_sel        = PC_SEQ;
      redirect_addr = '0;
      ifid_we       = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      ex_stall      = 1'b0;
      icache_inv    = 1'b0;
      trap_o        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      trap_cause_q <= '0;
      trap_epc_q   <= '0;
      fencei_pc_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trap_cause_q <= trap_cause_d;
      trap_epc_q   <= trap_epc_d;
      fencei_pc_q  <= fencei_pc_d;
    end
  end

  assign trap_cause = trap_cause_q;
  assign trap_epc   = trap_epc_q;
  assign state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a behavioural sequencing model.
// Revision: 1.0
`default_nettype none

module tb_pipe_ctrl;

  localparam int FC = 4;
  localparam int MT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_fencei, id_trap, ex_valid, ex_br_taken, mem_req, mem_ack;
  logic [31:0] id_pc, ex_br_target, trap_vec;
  logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
  logic [1:0]  ex_mem_rw;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, ex_stall, icache_inv, trap_o;
  logic [1:0]  pc_sel, state_o;
  logic [31:0] redirect_addr, trap_epc;
  logic [3:0]  trap_cause;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FENCEI_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr),
    .id_fencei(id_fencei), .id_trap(id_trap),
    .ex_valid(ex_valid), .ex_rd_waddr(ex_rd_waddr), .ex_mem_rw(ex_mem_rw),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .mem_req(mem_req), .mem_ack(mem_ack), .trap_vec(trap_vec),
    .pc_we(pc_we), .pc_sel(pc_sel), .redirect_addr(redirect_addr),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .ex_stall(ex_stall),
    .icache_inv(icache_inv), .trap_o(trap_o), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .state_o(state_o)
  );

  // Behavioural model: mode 0 running, 1 waiting on memory, 2 draining, 3 trap pulse
  int          m_mode, m_waited, m_left;
  logic [31:0] m_fpc, m_epc;
  logic [3:0]  m_cause;
  int          n_mode, n_waited, n_left;
  logic [31:0] n_fpc, n_epc;
  logic [3:0]  n_cause;
  logic        e_pc_we, e_ifid_we, e_ifid_fl, e_idex_fl, e_stall, e_inv, e_trap;
  logic [1:0]  e_sel;
  logic [31:0] e_redir;

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_left = 0; m_fpc = 0; m_epc = 0; m_cause = 0;
  endtask

  task automatic model_eval();
    bit hazard;
    n_mode = m_mode; n_waited = m_waited; n_left = m_left;
    n_fpc = m_fpc; n_epc = m_epc; n_cause = m_cause;
    e_pc_we = 1; e_ifid_we = 1; e_sel = 2'd0; e_redir = 0;
    e_ifid_fl = 0; e_idex_fl = 0; e_stall = 0; e_inv = 0; e_trap = 0;
    hazard = ex_valid && ex_mem_rw == 2'd1 && ex_rd_waddr != 0 && id_valid &&
             (ex_rd_waddr == id_rs1_raddr || ex_rd_waddr == id_rs2_raddr);
    case (m_mode)
      0: begin
        if (ex_valid && ex_br_taken) begin
          e_sel = 2'd1; e_redir = ex_br_target; e_ifid_fl = 1; e_idex_fl = 1;
        end else if (mem_req && !mem_ack) begin
          e_pc_we = 0; e_ifid_we = 0; e_stall = 1; n_mode = 1; n_waited = 1;
        end else if (hazard) begin
          e_pc_we = 0; e_ifid_we = 0; e_idex_fl = 1;
        end else if (id_valid && id_trap) begin
          e_sel = 2'd1; e_redir = trap_vec; e_ifid_fl = 1; e_idex_fl = 1;
          n_epc = id_pc; n_cause = id_pc[20] ? 4'd3 : 4'd11; n_mode = 3;
        end else if (id_valid && id_fencei) begin
          e_pc_we = 0; e_ifid_we = 0; e_inv = 1; n_fpc = id_pc; n_mode = 2; n_left = FC - 1;
        end
      end
      1: begin
        e_pc_we = 0; e_ifid_we = 0; e_stall = 1;
        if (mem_ack) begin
          e_pc_we = 1; e_ifid_we = 1; e_stall = 0; n_mode = 0;
        end else if (m_waited == MT - 1) begin
          e_pc_we = 1; e_sel = 2'd1; e_redir = trap_vec; e_ifid_fl = 1; e_idex_fl = 1;
          e_stall = 0; n_cause = 4'd5; n_epc = id_pc; n_mode = 3;
        end else begin
          n_waited = m_waited + 1;
        end
      end
      2: begin
        e_pc_we = 0; e_ifid_we = 0; e_idex_fl = 1;
        if (m_left == 0) begin
          e_pc_we = 1; e_sel = 2'd1; e_redir = m_fpc + 32'd4; e_ifid_fl = 1; n_mode = 0;
        end else begin
          n_left = m_left - 1;
        end
      end
      default: begin
        e_trap = 1; e_ifid_fl = 1; e_idex_fl = 1; n_mode = 0;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc_we"}, 32'(pc_we), 0);
    chk({tag, ".pc_sel"}, 32'(pc_sel), 0);
    chk({tag, ".redir"}, redirect_addr, 0);
    chk({tag, ".ifid_we"}, 32'(ifid_we), 0);
    chk({tag, ".flushes"}, 32'({ifid_flush, idex_flush}), 0);
    chk({tag, ".ex_stall"}, 32'(ex_stall), 0);
    chk({tag, ".inv_trap"}, 32'({icache_inv, trap_o}), 0);
    chk({tag, ".cause"}, 32'(trap_cause), 0);
    chk({tag, ".epc"}, trap_epc, 0);
    chk({tag, ".state"}, 32'(state_o), 0);
  endtask

  // Compare one cycle at the falling edge, then advance the model past the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".pc_we"}, 32'(pc_we), 32'(e_pc_we));
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(e_sel));
    if (e_sel == 2'd1) chk({tag, ".redir"}, redirect_addr, e_redir);
    chk({tag, ".ifid_we"}, 32'(ifid_we), 32'(e_ifid_we));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_ifid_fl));
    chk({tag, ".idex_flush"}, 32'(idex_flush), 32'(e_idex_fl));
    chk({tag, ".ex_stall"}, 32'(ex_stall), 32'(e_stall));
    chk({tag, ".icache_inv"}, 32'(icache_inv), 32'(e_inv));
    chk({tag, ".trap_o"}, 32'(trap_o), 32'(e_trap));
    chk({tag, ".state"}, 32'(state_o), 32'(m_mode));
    if (e_trap) begin
      chk({tag, ".cause"}, 32'(trap_cause), 32'(m_cause));
      chk({tag, ".epc"}, trap_epc, m_epc);
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_waited = n_waited; m_left = n_left;
    m_fpc = n_fpc; m_epc = n_epc; m_cause = n_cause;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1_raddr = 0; id_rs2_raddr = 0; id_fencei = 0; id_trap = 0;
    ex_valid = 0; ex_rd_waddr = 0; ex_mem_rw = 0; ex_br_taken = 0; ex_br_target = 0;
    mem_req = 0; mem_ack = 0; trap_vec = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    // load-use on rs2, then cleared by the bubble, then a load to x0
    ex_valid = 1; ex_mem_rw = 2'd1; ex_rd_waddr = 5'd5; id_valid = 1; id_rs1_raddr = 5'd3; id_rs2_raddr = 5'd5;
    step("lu");
    ex_valid = 0;
    step("lu_clear");
    ex_valid = 1; ex_rd_waddr = 5'd0; id_rs1_raddr = 5'd0; id_rs2_raddr = 5'd0;
    step("lu_x0");

    // taken branch outranks a concurrent load-use
    ex_rd_waddr = 5'd7; id_rs1_raddr = 5'd7; ex_br_taken = 1; ex_br_target = 32'h100;
    step("br_lu");
    idle();
    step("idle0");

    // memory wait released by an ack on the fourth cycle
    mem_req = 1;
    repeat (3) step("mw");
    mem_ack = 1;
    step("mw_ack");
    idle();
    step("idle1");

    // memory timeout into a bus-error trap
    mem_req = 1; id_pc = 32'h1234; trap_vec = 32'h300;
    repeat (MT) step("mto");
    mem_req = 0;
    step("mto_trap");
    step("idle2");

    // FENCE.I at 0x80 and at the top of the address space
    for (int k = 0; k < 2; k++) begin
      idle();
      id_valid = 1; id_fencei = 1; id_pc = (k == 0) ? 32'h80 : 32'hFFFF_FFFC;
      step("fi");
      idle();
      repeat (FC) step("fi_drain");
      step("fi_after");
    end

    // ECALL at 0x40
    id_valid = 1; id_trap = 1; id_pc = 32'h40; trap_vec = 32'h200;
    step("ecall");
    idle();
    step("ecall_trap");
    step("idle3");

    // asynchronous reset in the middle of a drain
    id_valid = 1; id_fencei = 1; id_pc = 32'h500;
    step("fi_rst");
    idle();
    step("fi_rst_drain");
    rst = 1;
    #1;
    chk_all_zero("rst_mid_drain");
    model_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    step("post_rst");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_pc        = $urandom;
      id_rs1_raddr = 5'($urandom_range(0, 7));
      id_rs2_raddr = 5'($urandom_range(0, 7));
      id_fencei    = ($urandom_range(0, 15) == 0);
      id_trap      = ($urandom_range(0, 15) == 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_rd_waddr  = 5'($urandom_range(0, 7));
      ex_mem_rw    = 2'($urandom_range(0, 3));
      ex_br_taken  = ($urandom_range(0, 7) == 0);
      ex_br_target = $urandom;
      mem_req      = ($urandom_range(0, 5) == 0);
      mem_ack      = ($urandom_range(0, 4) == 0);
      trap_vec     = $urandom;
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
